// File: rtl/riscv_multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RISC-V control path:
// instruction classes, immediate formats, sequencer states, mux selects
// and trap causes.
package riscv_multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    UNKNOWN_TYPE
  } instruction_type_e;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [2:0] {
    FETCH,
    FETCH_WAIT,
    DECODE,
    EXECUTE,
    MEM,
    MEM_WAIT,
    WRITEBACK,
    TRAP
  } ctrl_state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_IMEM_TMO = 2'd2,
    CAUSE_DMEM_TMO = 2'd3
  } trap_cause_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // States in which the sequencer waits on a memory handshake and the
  // timeout counter runs.
  function automatic logic is_timed_state(input ctrl_state_e s);
    return (s == FETCH) || (s == FETCH_WAIT) || (s == MEM) || (s == MEM_WAIT);
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Instruction- and data-memory valid/ready handshake bundle. The
// controller drives requests (master); the memory side answers (slave).
interface riscv_multicycle_ctrl_if;

  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        dmem_req_valid_o;
  logic        dmem_we_o;
  logic        dmem_req_ready_i;
  logic        dmem_rsp_valid_i;

  modport master (
    output imem_req_valid_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    output dmem_req_valid_o,
    output dmem_we_o,
    input  dmem_req_ready_i,
    input  dmem_rsp_valid_i
  );

  modport slave (
    input  imem_req_valid_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    input  dmem_req_valid_o,
    input  dmem_we_o,
    output dmem_req_ready_i,
    output dmem_rsp_valid_i
  );

endinterface

// File: rtl/riscv_multicycle_ctrl_classify.sv
// Combinational instruction classifier: maps the opcode field of an
// instruction word to its class, immediate format and the few opcode
// flags the sequencer needs. Kept standalone so a pipelined core can
// reuse it in its decode stage.
module riscv_instr_classify
  import riscv_multicycle_ctrl_pkg::*;
(
  input  logic [31:0]       i_ir,
  output instruction_type_e o_instr_type,
  output imm_type_e         o_imm_type,
  output logic              o_is_load,
  output logic              o_is_jal,
  output logic              o_is_jalr,
  output logic              o_is_lui
);

  logic [6:0] w_opcode;
  logic       w_unused_ir;

  assign w_opcode    = i_ir[6:0];
  assign w_unused_ir = ^i_ir[31:7];

  assign o_is_load = (w_opcode == OPC_LOAD);
  assign o_is_jal  = (w_opcode == OPC_JAL);
  assign o_is_jalr = (w_opcode == OPC_JALR);
  assign o_is_lui  = (w_opcode == OPC_LUI);

  // Opcode to class / immediate-format lookup; anything unlisted is illegal.
  always_comb begin
    o_instr_type = UNKNOWN_TYPE;
    o_imm_type   = IMM_NONE;
    case (w_opcode)
      OPC_OP: begin
        o_instr_type = R_TYPE;
        o_imm_type   = IMM_NONE;
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        o_instr_type = I_TYPE;
        o_imm_type   = IMM_I;
      end
      OPC_STORE: begin
        o_instr_type = S_TYPE;
        o_imm_type   = IMM_S;
      end
      OPC_BRANCH: begin
        o_instr_type = B_TYPE;
        o_imm_type   = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_instr_type = U_TYPE;
        o_imm_type   = IMM_U;
      end
      OPC_JAL: begin
        o_instr_type = J_TYPE;
        o_imm_type   = IMM_J;
      end
      default: begin
        o_instr_type = UNKNOWN_TYPE;
        o_imm_type   = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle sequencer for the toy RISC-V core. Owns the instruction
// register, walks each instruction through fetch/decode/execute/memory/
// writeback, drives the memory handshakes and datapath strobes, counts
// retired instructions and halts in TRAP on illegal opcodes or on a
// memory handshake that stalls for TIMEOUT_CYCLES cycles.
module riscv_multicycle_ctrl
  import riscv_multicycle_ctrl_pkg::*;
#(
  parameter int          CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  riscv_multicycle_ctrl_if.master   bus,
  output logic [31:0]               ir_o,
  output instruction_type_e         instr_type_o,
  output imm_type_e                 imm_type_o,
  input  logic                      branch_taken_i,
  output logic                      pc_write_o,
  output logic [1:0]                pc_sel_o,
  output logic                      rf_we_o,
  output logic [1:0]                wb_sel_o,
  output logic [CNT_W-1:0]          retire_cnt_o,
  output logic                      trap_o,
  output logic [1:0]                trap_cause_o
);

  // Value of the timeout counter on the last permitted waiting cycle.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  ctrl_state_e       r_state;
  ctrl_state_e       w_state_nxt;
  logic [31:0]       r_ir;
  logic [CNT_W-1:0]  r_retire_cnt;
  logic [31:0]       r_tmo_cnt;
  trap_cause_e       r_trap_cause;
  trap_cause_e       w_trap_cause_nxt;

  instruction_type_e w_instr_type;
  imm_type_e         w_imm_type;
  logic              w_is_load;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_is_lui;

  logic              w_tmo_hit;
  logic              w_retire;
  logic              w_imem_req_valid;
  logic              w_dmem_req_valid;
  logic              w_dmem_we;
  logic              w_rf_we;
  pc_sel_e           w_pc_sel;
  wb_sel_e           w_wb_sel;

  riscv_instr_classify u_classify (
    .i_ir         (r_ir),
    .o_instr_type (w_instr_type),
    .o_imm_type   (w_imm_type),
    .o_is_load    (w_is_load),
    .o_is_jal     (w_is_jal),
    .o_is_jalr    (w_is_jalr),
    .o_is_lui     (w_is_lui)
  );

  // A zero TIMEOUT_CYCLES never fires.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_tmo_cnt == TMO_LAST);

  // Next-state and per-state strobes; a handshake completing this cycle
  // is tested before the timeout so it always wins the tie.
  always_comb begin
    w_state_nxt      = r_state;
    w_trap_cause_nxt = CAUSE_NONE;
    w_retire         = 1'b0;
    w_imem_req_valid = 1'b0;
    w_dmem_req_valid = 1'b0;
    w_dmem_we        = 1'b0;
    w_rf_we          = 1'b0;
    w_pc_sel         = PC_PLUS4;
    w_wb_sel         = WB_ALU;
    case (r_state)
      FETCH: begin
        w_imem_req_valid = 1'b1;
        if (bus.imem_req_ready_i) begin
          w_state_nxt = FETCH_WAIT;
        end else if (w_tmo_hit) begin
          w_state_nxt      = TRAP;
          w_trap_cause_nxt = CAUSE_IMEM_TMO;
        end
      end
      FETCH_WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          w_state_nxt = DECODE;
        end else if (w_tmo_hit) begin
          w_state_nxt      = TRAP;
          w_trap_cause_nxt = CAUSE_IMEM_TMO;
        end
      end
      DECODE: begin
        if (w_instr_type == UNKNOWN_TYPE) begin
          w_state_nxt      = TRAP;
          w_trap_cause_nxt = CAUSE_ILLEGAL;
        end else begin
          w_state_nxt = EXECUTE;
        end
      end
      EXECUTE: begin
        if (w_is_load || (w_instr_type == S_TYPE)) begin
          w_state_nxt = MEM;
        end else if (w_instr_type == B_TYPE) begin
          w_retire = 1'b1;
          if (branch_taken_i) begin
            w_pc_sel = PC_IMM;
          end
        end else begin
          w_state_nxt = WRITEBACK;
        end
      end
      MEM: begin
        w_dmem_req_valid = 1'b1;
        w_dmem_we        = (w_instr_type == S_TYPE);
        if (bus.dmem_req_ready_i) begin
          w_state_nxt = MEM_WAIT;
        end else if (w_tmo_hit) begin
          w_state_nxt      = TRAP;
          w_trap_cause_nxt = CAUSE_DMEM_TMO;
        end
      end
      MEM_WAIT: begin
        if (bus.dmem_rsp_valid_i) begin
          if (w_instr_type == S_TYPE) begin
            w_retire = 1'b1;
          end else begin
            w_state_nxt = WRITEBACK;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt      = TRAP;
          w_trap_cause_nxt = CAUSE_DMEM_TMO;
        end
      end
      WRITEBACK: begin
        w_rf_we  = 1'b1;
        w_retire = 1'b1;
        if (w_is_load) begin
          w_wb_sel = WB_MEM;
        end else if (w_is_jal || w_is_jalr) begin
          w_wb_sel = WB_PC4;
        end else if (w_is_lui) begin
          w_wb_sel = WB_IMM;
        end
        if (w_is_jal) begin
          w_pc_sel = PC_IMM;
        end else if (w_is_jalr) begin
          w_pc_sel = PC_ALU;
        end
      end
      TRAP: begin
        w_state_nxt = TRAP;
      end
      default: begin
        w_state_nxt = FETCH;
      end
    endcase
    // Every retiring state updates the PC and returns to fetch.
    if (w_retire) begin
      w_state_nxt = FETCH;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the fetched instruction when its response arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= '0;
    end else if ((r_state == FETCH_WAIT) && bus.imem_rsp_valid_i) begin
      r_ir <= bus.imem_rsp_data_i;
    end
  end

  // Retired-instruction count, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_retire) begin
      r_retire_cnt <= r_retire_cnt + CNT_W'(1);
    end
  end

  // Cycles spent in the current memory-wait state; restarts on any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmo_cnt <= '0;
    end else if (is_timed_state(r_state)) begin
      r_tmo_cnt <= r_tmo_cnt + 32'd1;
    end
  end

  // Latch the trap cause on entry to TRAP; it stays until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_trap_cause <= CAUSE_NONE;
    end else if ((r_state != TRAP) && (w_state_nxt == TRAP)) begin
      r_trap_cause <= w_trap_cause_nxt;
    end
  end

  assign bus.imem_req_valid_o = w_imem_req_valid;
  assign bus.dmem_req_valid_o = w_dmem_req_valid;
  assign bus.dmem_we_o        = w_dmem_we;

  assign ir_o         = r_ir;
  assign instr_type_o = w_instr_type;
  assign imm_type_o   = w_imm_type;
  assign pc_write_o   = w_retire;
  assign pc_sel_o     = w_pc_sel;
  assign rf_we_o      = w_rf_we;
  assign wb_sel_o     = w_wb_sel;
  assign retire_cnt_o = r_retire_cnt;
  assign trap_o       = (r_state == TRAP);
  assign trap_cause_o = r_trap_cause;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: a small memory responder
// drives the handshakes with configurable delays while per-instruction
// observations are compared with hand-computed expectations.
module tb_riscv_multicycle_ctrl;
  import riscv_multicycle_ctrl_pkg::*;

  localparam int CNT_W = 4;

  logic              clk;
  logic              rst;
  logic              branch_taken;
  logic [31:0]       ir;
  instruction_type_e instr_type;
  imm_type_e         imm_type;
  logic              pc_write;
  logic [1:0]        pc_sel;
  logic              rf_we;
  logic [1:0]        wb_sel;
  logic [CNT_W-1:0]  retire_cnt;
  logic              trap;
  logic [1:0]        trap_cause;

  riscv_multicycle_ctrl_if bus ();

  riscv_multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .ir_o           (ir),
    .instr_type_o   (instr_type),
    .imm_type_o     (imm_type),
    .branch_taken_i (branch_taken),
    .pc_write_o     (pc_write),
    .pc_sel_o       (pc_sel),
    .rf_we_o        (rf_we),
    .wb_sel_o       (wb_sel),
    .retire_cnt_o   (retire_cnt),
    .trap_o         (trap),
    .trap_cause_o   (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_retire = 0;

  // Observations from the most recent run_instr call.
  int         done_cyc, trap_cyc, rfwe_cyc, rfwe_cnt, dreq_cnt;
  logic       dwe_seen;
  logic [1:0] obs_wb, obs_pc, obs_cause;
  logic [2:0] obs_type, obs_imm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'h0;
    bus.dmem_req_ready_i = 1'b0;
    bus.dmem_rsp_valid_i = 1'b0;
    branch_taken         = 1'b0;
  endtask

  // Asynchronous reset pulse; outputs are checked before any clock edge.
  task automatic do_reset();
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    #2;
    chk("rst_trap", trap, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_ir", ir, 0);
    chk("rst_pcw", pc_write, 0);
    chk("rst_rfwe", rf_we, 0);
    chk("rst_dreq", bus.dmem_req_valid_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_retire = 0;
  endtask

  // Memory responder: cycle 1 is the current cycle. Ready is given on the
  // (delay+1)-th request cycle and the response on the following cycle.
  task automatic run_instr(input logic [31:0] instr, input int idly, input int ddly,
                           input logic taken, input logic hold_drsp, input int max_cyc);
    int   icnt, dcnt;
    logic ipend, dpend;
    icnt = 0; dcnt = 0; ipend = 1'b0; dpend = 1'b0;
    done_cyc = 0; trap_cyc = 0; rfwe_cyc = 0; rfwe_cnt = 0; dreq_cnt = 0;
    dwe_seen = 1'b0; obs_wb = 2'd0; obs_pc = 2'd0; obs_cause = 2'd0;
    obs_type = 3'd0; obs_imm = 3'd0;
    for (int c = 1; c <= max_cyc; c++) begin
      bus.imem_rsp_valid_i = ipend;
      bus.imem_rsp_data_i  = ipend ? instr : 32'h0;
      bus.dmem_rsp_valid_i = dpend && !hold_drsp;
      ipend = 1'b0;
      dpend = 1'b0;
      bus.imem_req_ready_i = 1'b0;
      bus.dmem_req_ready_i = 1'b0;
      branch_taken = taken;
      if (bus.imem_req_valid_o) begin
        icnt++;
        if (icnt > idly) begin
          bus.imem_req_ready_i = 1'b1;
          ipend = 1'b1;
        end
      end
      if (bus.dmem_req_valid_o) begin
        dcnt++;
        dreq_cnt++;
        dwe_seen = dwe_seen | bus.dmem_we_o;
        if (dcnt > ddly) begin
          bus.dmem_req_ready_i = 1'b1;
          dpend = 1'b1;
        end
      end
      #1;
      if (rf_we) begin
        rfwe_cnt++;
        rfwe_cyc = c;
        obs_wb = wb_sel;
      end
      if (pc_write) begin
        done_cyc = c;
        obs_pc   = pc_sel;
        obs_type = instr_type;
        obs_imm  = imm_type;
      end
      if (trap) begin
        trap_cyc  = c;
        obs_cause = trap_cause;
        obs_type  = instr_type;
      end
      @(posedge clk); #1;
      if ((done_cyc != 0) || (trap_cyc != 0)) break;
    end
    idle_inputs();
  endtask

  // Checks for an instruction that retires through WRITEBACK.
  task automatic chk_wb_instr(input string tag, input logic [31:0] instr, input int cyc,
                              input logic [1:0] wb, input logic [1:0] pcs,
                              input instruction_type_e t, input imm_type_e im);
    run_instr(instr, 0, 0, 1'b0, 1'b0, 20);
    exp_retire++;
    chk({tag, "_cyc"}, done_cyc, cyc);
    chk({tag, "_rfwe_cyc"}, rfwe_cyc, cyc);
    chk({tag, "_wb"}, obs_wb, wb);
    chk({tag, "_pcsel"}, obs_pc, pcs);
    chk({tag, "_type"}, obs_type, t);
    chk({tag, "_imm"}, obs_imm, im);
    chk({tag, "_retire"}, retire_cnt, exp_retire % 16);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    do_reset();

    // ALU immediate, zero wait.
    chk_wb_instr("addi", 32'h00500093, 5, 2'd0, 2'd0, I_TYPE, IMM_I);
    chk("addi_rfwe_cnt", rfwe_cnt, 1);
    chk("addi_pcw_one_cycle", pc_write, 0);

    // Load with dmem ready delayed by three cycles.
    run_instr(32'h00002103, 0, 3, 1'b0, 1'b0, 20);
    exp_retire++;
    chk("lw_cyc", done_cyc, 10);
    chk("lw_dreq_cycles", dreq_cnt, 4);
    chk("lw_dwe", dwe_seen, 0);
    chk("lw_wb", obs_wb, 1);
    chk("lw_rfwe_cyc", rfwe_cyc, 10);
    chk("lw_type", obs_type, I_TYPE);
    chk("lw_retire", retire_cnt, exp_retire % 16);

    // Store, zero wait.
    run_instr(32'h00102023, 0, 0, 1'b0, 1'b0, 20);
    exp_retire++;
    chk("sw_cyc", done_cyc, 6);
    chk("sw_dwe", dwe_seen, 1);
    chk("sw_dreq_cycles", dreq_cnt, 1);
    chk("sw_rfwe_cnt", rfwe_cnt, 0);
    chk("sw_pcsel", obs_pc, 0);
    chk("sw_type", obs_type, S_TYPE);
    chk("sw_imm", obs_imm, IMM_S);

    // Branch taken and not taken.
    run_instr(32'h00000463, 0, 0, 1'b1, 1'b0, 20);
    exp_retire++;
    chk("beq_t_cyc", done_cyc, 4);
    chk("beq_t_pcsel", obs_pc, 1);
    chk("beq_t_rfwe_cnt", rfwe_cnt, 0);
    chk("beq_t_type", obs_type, B_TYPE);
    chk("beq_t_imm", obs_imm, IMM_B);
    run_instr(32'h00000463, 0, 0, 1'b0, 1'b0, 20);
    exp_retire++;
    chk("beq_nt_cyc", done_cyc, 4);
    chk("beq_nt_pcsel", obs_pc, 0);

    chk_wb_instr("jal",   32'h0000006F, 5, 2'd2, 2'd1, J_TYPE, IMM_J);
    chk_wb_instr("jalr",  32'h00008067, 5, 2'd2, 2'd2, I_TYPE, IMM_I);
    chk_wb_instr("lui",   32'h000010B7, 5, 2'd3, 2'd0, U_TYPE, IMM_U);
    chk_wb_instr("auipc", 32'h00000097, 5, 2'd0, 2'd0, U_TYPE, IMM_U);
    chk_wb_instr("add",   32'h002081B3, 5, 2'd0, 2'd0, R_TYPE, IMM_NONE);

    // Fetch ready on the last permitted cycle: handshake beats the timeout.
    run_instr(32'h00500093, 3, 0, 1'b0, 1'b0, 20);
    exp_retire++;
    chk("fetch_late_cyc", done_cyc, 8);
    chk("fetch_late_notrap", trap_cyc, 0);

    // Retire counter wraps past 2^CNT_W.
    for (int k = 0; k < 6; k++) begin
      run_instr(32'h00000463, 0, 0, 1'b0, 1'b0, 20);
      exp_retire++;
    end
    chk("wrap_retire", retire_cnt, exp_retire % 16);

    // Illegal opcode traps after DECODE and stays halted.
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 20);
    chk("ill_trap_cyc", trap_cyc, 4);
    chk("ill_cause", obs_cause, 1);
    chk("ill_type", obs_type, UNKNOWN_TYPE);
    chk("ill_retire", retire_cnt, exp_retire % 16);
    chk("ill_rfwe_cnt", rfwe_cnt, 0);
    bus.imem_req_ready_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ill_sticky", trap, 1);
    chk("ill_no_fetch", bus.imem_req_valid_o, 0);
    do_reset();
    chk("ill_rst_type", instr_type, UNKNOWN_TYPE);
    chk("ill_rst_imm", imm_type, IMM_NONE);
    chk("ill_rst_fetch", bus.imem_req_valid_o, 1);

    // Fetch never accepted: imem timeout after four cycles in FETCH.
    run_instr(32'h00500093, 100, 0, 1'b0, 1'b0, 20);
    chk("itmo_trap_cyc", trap_cyc, 5);
    chk("itmo_cause", obs_cause, 2);
    do_reset();

    // Store never accepted: dmem timeout after four cycles in MEM.
    run_instr(32'h00102023, 0, 100, 1'b0, 1'b0, 20);
    chk("dtmo_trap_cyc", trap_cyc, 9);
    chk("dtmo_cause", obs_cause, 3);
    chk("dtmo_dreq_cycles", dreq_cnt, 4);
    do_reset();

    // Reset while a store waits for its response, then a stale response.
    run_instr(32'h00102023, 0, 0, 1'b0, 1'b1, 6);
    chk("swrst_not_done", done_cyc, 0);
    do_reset();
    bus.dmem_rsp_valid_i = 1'b1;
    #1;
    chk("stale_pcw", pc_write, 0);
    chk("stale_fetch", bus.imem_req_valid_o, 1);
    chk("stale_dreq", bus.dmem_req_valid_o, 0);
    @(posedge clk); #1;
    bus.dmem_rsp_valid_i = 1'b0;
    chk("stale_retire", retire_cnt, 0);
    chk("stale_still_fetch", bus.imem_req_valid_o, 1);
    run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 20);
    exp_retire++;
    chk("after_rst_cyc", done_cyc, 5);
    chk("after_rst_retire", retire_cnt, exp_retire % 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
